// File: rtl/alu_cmd_sequencer.sv
// Request FIFO and one-at-a-time issue sequencer in front of the registered-input ALU.
// Results are captured in the single cycle the ALU presents them and returned with the request tag.
module alu_cmd_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    req_opa,
  input  logic [N-1:0]    req_opb,
  input  logic            req_cin,
  input  logic            req_mode,
  input  logic [3:0]      req_cmd,
  input  logic [1:0]      req_inp_valid,
  input  logic [TAGW-1:0] req_tag,
  output logic            alu_ce,
  output logic [N-1:0]    alu_opa,
  output logic [N-1:0]    alu_opb,
  output logic            alu_cin,
  output logic            alu_mode,
  output logic [3:0]      alu_cmd,
  output logic [1:0]      alu_inp_valid,
  input  logic [2*N:0]    alu_res,
  input  logic [6:0]      alu_flags,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*N:0]    rsp_res,
  output logic [6:0]      rsp_flags,
  output logic [TAGW-1:0] rsp_tag,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SAMPLE, RESP} state_t;

  typedef struct packed {
    logic [N-1:0]    opa;
    logic [N-1:0]    opb;
    logic            cin;
    logic            mode;
    logic [3:0]      cmd;
    logic [1:0]      inp_valid;
    logic [TAGW-1:0] tag;
    logic            mul;
  } entry_t;

  entry_t mem_q [DEPTH];
  entry_t push_entry;
  entry_t head;

  state_t          state_q, state_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TAGW-1:0] wk_tag_q, wk_tag_d;
  logic            wk_mul_q, wk_mul_d;
  logic            alu_ce_q, alu_ce_d;
  logic [N-1:0]    alu_opa_q, alu_opa_d, alu_opb_q, alu_opb_d;
  logic            alu_cin_q, alu_cin_d, alu_mode_q, alu_mode_d;
  logic [3:0]      alu_cmd_q, alu_cmd_d;
  logic [1:0]      alu_inp_valid_q, alu_inp_valid_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [2*N:0]    rsp_res_q, rsp_res_d;
  logic [6:0]      rsp_flags_q, rsp_flags_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;

  logic full, empty, push, pop, req_mul;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign req_ready = !full && !RST;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && !empty;
  assign head      = mem_q[rd_ptr_q[PW-1:0]];

  assign req_mul = req_mode && (req_inp_valid == 2'b11) &&
                   ((req_cmd == 4'b1001) || (req_cmd == 4'b1010));

  always_comb begin
    push_entry.opa       = req_opa;
    push_entry.opb       = req_opb;
    push_entry.cin       = req_cin;
    push_entry.mode      = req_mode;
    push_entry.cmd       = req_cmd;
    push_entry.inp_valid = req_inp_valid;
    push_entry.tag       = req_tag;
    push_entry.mul       = req_mul;
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_entry;
  end

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d        = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d           = cnt_q;
    wk_tag_d        = wk_tag_q;
    wk_mul_d        = wk_mul_q;
    alu_ce_d        = 1'b1;
    alu_opa_d       = alu_opa_q;
    alu_opb_d       = alu_opb_q;
    alu_cin_d       = alu_cin_q;
    alu_mode_d      = alu_mode_q;
    alu_cmd_d       = alu_cmd_q;
    alu_inp_valid_d = 2'b00;
    rsp_valid_d     = rsp_valid_q;
    rsp_res_d       = rsp_res_q;
    rsp_flags_d     = rsp_flags_q;
    rsp_tag_d       = rsp_tag_q;
    unique case (state_q)
      IDLE: begin
        // Operands are registered at pop so they are on the ALU port throughout ISSUE.
        if (pop) begin
          alu_opa_d       = head.opa;
          alu_opb_d       = head.opb;
          alu_cin_d       = head.cin;
          alu_mode_d      = head.mode;
          alu_cmd_d       = head.cmd;
          alu_inp_valid_d = head.inp_valid;
          wk_tag_d        = head.tag;
          wk_mul_d        = head.mul;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = wk_mul_q ? 2'd2 : 2'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      SAMPLE: begin
        rsp_res_d   = alu_res;
        rsp_flags_d = alu_flags;
        rsp_tag_d   = wk_tag_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      wk_tag_q        <= '0;
      wk_mul_q        <= 1'b0;
      alu_ce_q        <= 1'b0;
      alu_opa_q       <= '0;
      alu_opb_q       <= '0;
      alu_cin_q       <= 1'b0;
      alu_mode_q      <= 1'b0;
      alu_cmd_q       <= '0;
      alu_inp_valid_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_res_q       <= '0;
      rsp_flags_q     <= '0;
      rsp_tag_q       <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      wk_tag_q        <= wk_tag_d;
      wk_mul_q        <= wk_mul_d;
      alu_ce_q        <= alu_ce_d;
      alu_opa_q       <= alu_opa_d;
      alu_opb_q       <= alu_opb_d;
      alu_cin_q       <= alu_cin_d;
      alu_mode_q      <= alu_mode_d;
      alu_cmd_q       <= alu_cmd_d;
      alu_inp_valid_q <= alu_inp_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_res_q       <= rsp_res_d;
      rsp_flags_q     <= rsp_flags_d;
      rsp_tag_q       <= rsp_tag_d;
    end
  end

  assign alu_ce        = alu_ce_q;
  assign alu_opa       = alu_opa_q;
  assign alu_opb       = alu_opb_q;
  assign alu_cin       = alu_cin_q;
  assign alu_mode      = alu_mode_q;
  assign alu_cmd       = alu_cmd_q;
  assign alu_inp_valid = alu_inp_valid_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_res       = rsp_res_q;
  assign rsp_flags     = rsp_flags_q;
  assign rsp_tag       = rsp_tag_q;
  assign busy          = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small ALU stand-in that presents
// each result for exactly one cycle after its fixed latency.
module tb_alu_cmd_sequencer;
  localparam int N    = 8;
  localparam int TAGW = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [N-1:0]    req_opa = '0;
  logic [N-1:0]    req_opb = '0;
  logic            req_cin = 1'b0;
  logic            req_mode = 1'b0;
  logic [3:0]      req_cmd = '0;
  logic [1:0]      req_inp_valid = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic            alu_ce;
  logic [N-1:0]    alu_opa, alu_opb;
  logic            alu_cin, alu_mode;
  logic [3:0]      alu_cmd;
  logic [1:0]      alu_inp_valid;
  logic [2*N:0]    alu_res;
  logic [6:0]      alu_flags;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [2*N:0]    rsp_res;
  logic [6:0]      rsp_flags;
  logic [TAGW-1:0] rsp_tag;
  logic            busy;

  int compared = 0;
  int mismatched = 0;

  alu_cmd_sequencer #(.N(N), .DEPTH(4), .TAGW(TAGW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_inp_valid(req_inp_valid), .req_tag(req_tag),
    .alu_ce(alu_ce), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
    .alu_mode(alu_mode), .alu_cmd(alu_cmd), .alu_inp_valid(alu_inp_valid),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // ALU stand-in: flags {overflow, ERR, E, L, G, OFLOW, COUT}
  function automatic logic [2*N+7:0] alu_fn(input logic mode, input logic [3:0] cmd,
                                             input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N:0] r;
    logic [6:0]   f;
    r = '0;
    f = '0;
    if (mode) begin
      case (cmd)
        4'b0000: begin
          r = {{(N+1){1'b0}}, a} + {{(N+1){1'b0}}, b};
          f[0] = r[N];
        end
        4'b1000: begin
          f[4] = (a == b);
          f[3] = (a < b);
          f[2] = (a > b);
        end
        4'b1001: r = ({{(N+1){1'b0}}, a} + 1) * ({{(N+1){1'b0}}, b} + 1);
        4'b1010: r = {{N{1'b0}}, a, 1'b0} * {{(N+1){1'b0}}, b};
        default: f[5] = 1'b1;
      endcase
    end else begin
      case (cmd)
        4'b0000: r = {{(N+1){1'b0}}, a & b};
        default: f[5] = 1'b1;
      endcase
    end
    return {f, r};
  endfunction

  logic [2*N:0] m_res;
  logic [6:0]   m_flags;
  logic [2:0]   m_cnt;
  logic         m_mul;

  assign m_mul = alu_mode && (alu_inp_valid == 2'b11) &&
                 ((alu_cmd == 4'b1001) || (alu_cmd == 4'b1010));

  // Operands captured at the edge ending ISSUE; result shown 2 (or 3) edges later for one cycle.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_cnt   <= '0;
      m_res   <= '0;
      m_flags <= '0;
    end else if (alu_inp_valid != 2'b00) begin
      {m_flags, m_res} <= alu_fn(alu_mode, alu_cmd, alu_opa, alu_opb);
      m_cnt <= m_mul ? 3'd4 : 3'd3;
    end else if (m_cnt != 3'd0) begin
      m_cnt <= m_cnt - 3'd1;
    end
  end

  assign alu_res   = (m_cnt == 3'd1) ? m_res : '1;
  assign alu_flags = (m_cnt == 3'd1) ? m_flags : 7'h7F;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic setReq(input logic mode, input logic [3:0] cmd, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [TAGW-1:0] tag);
    req_mode      = mode;
    req_cmd       = cmd;
    req_opa       = a;
    req_opb       = b;
    req_cin       = 1'b0;
    req_inp_valid = 2'b11;
    req_tag       = tag;
  endtask

  task automatic applyStimulus(input logic mode, input logic [3:0] cmd, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [TAGW-1:0] tag);
    int n;
    setReq(mode, cmd, a, b, tag);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) checkOutput("req_accept_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitResponse(output int lat, output int iv_cycles);
    lat = 0;
    iv_cycles = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
      if (alu_inp_valid != 2'b00) iv_cycles++;
    end
    if (!rsp_valid) checkOutput("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, iv, got;
    logic take, acc5;

    tick();
    tick();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_alu_ce", 32'(alu_ce), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_alu_inp_valid", 32'(alu_inp_valid), 32'd0);
    checkOutput("rst_rsp_res", 32'(rsp_res), 32'd0);
    RST = 1'b0;
    tick();
    checkOutput("ce_after_rst", 32'(alu_ce), 32'd1);
    checkOutput("ready_after_rst", 32'(req_ready), 32'd1);

    applyStimulus(1'b1, 4'b0000, 8'hFF, 8'h01, 4'd3);
    waitResponse(lat, iv);
    checkOutput("add_latency", 32'(lat), 32'd5);
    checkOutput("add_res", 32'(rsp_res), 32'h100);
    checkOutput("add_flags", 32'(rsp_flags), 32'h01);
    checkOutput("add_tag", 32'(rsp_tag), 32'd3);
    checkOutput("add_busy", 32'(busy), 32'd1);
    consume();
    checkOutput("add_rsp_cleared", 32'(rsp_valid), 32'd0);

    applyStimulus(1'b1, 4'b1001, 8'd3, 8'd4, 4'd7);
    waitResponse(lat, iv);
    checkOutput("mul_latency", 32'(lat), 32'd6);
    checkOutput("mul_inp_valid_cycles", 32'(iv), 32'd1);
    checkOutput("mul_res", 32'(rsp_res), 32'h014);
    checkOutput("mul_tag", 32'(rsp_tag), 32'd7);
    consume();

    applyStimulus(1'b1, 4'b1000, 8'd5, 8'd9, 4'd1);
    waitResponse(lat, iv);
    checkOutput("cmp_res", 32'(rsp_res), 32'h0);
    checkOutput("cmp_flags", 32'(rsp_flags), 32'h08);
    consume();

    applyStimulus(1'b0, 4'b0000, 8'hF0, 8'h3C, 4'd2);
    waitResponse(lat, iv);
    checkOutput("and_latency", 32'(lat), 32'd5);
    checkOutput("and_res", 32'(rsp_res), 32'h030);
    checkOutput("and_flags", 32'(rsp_flags), 32'h00);
    checkOutput("and_tag", 32'(rsp_tag), 32'd2);
    consume();

    applyStimulus(1'b1, 4'b0000, 8'h12, 8'h34, 4'd9);
    waitResponse(lat, iv);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_res", 32'(rsp_res), 32'h046);
      checkOutput("bp_flags", 32'(rsp_flags), 32'h00);
      checkOutput("bp_tag", 32'(rsp_tag), 32'd9);
      checkOutput("bp_inp_valid", 32'(alu_inp_valid), 32'd0);
    end
    consume();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    for (int t = 0; t < 5; t++) begin
      setReq(1'b1, 4'b0000, N'(t), 8'h10, TAGW'(t));
      req_valid = 1'b1;
      checkOutput("fill_ready", 32'(req_ready), 32'd1);
      tick();
    end
    setReq(1'b1, 4'b0000, 8'd5, 8'h10, 4'd5);
    checkOutput("fill_full_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    got = 0;
    acc5 = 1'b0;
    for (int i = 0; i < 200 && got < 6; i++) begin
      if (rsp_valid) begin
        checkOutput("fill_order_tag", 32'(rsp_tag), 32'(got));
        checkOutput("fill_res", 32'(rsp_res), 32'(got + 16));
        got++;
      end
      take = req_valid && req_ready;
      tick();
      if (take) begin
        req_valid = 1'b0;
        acc5 = 1'b1;
      end
    end
    checkOutput("fill_count", 32'(got), 32'd6);
    checkOutput("fill_tag5_accepted", 32'(acc5), 32'd1);
    tick();
    rsp_ready = 1'b0;

    applyStimulus(1'b1, 4'b1001, 8'd6, 8'd7, 4'd6);
    tick();
    tick();
    tick();
    checkOutput("midmul_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_alu_ce", 32'(alu_ce), 32'd0);
    checkOutput("midrst_inp_valid", 32'(alu_inp_valid), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    tick();
    checkOutput("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b1, 4'b0000, 8'd1, 8'd2, 4'd4);
    waitResponse(lat, iv);
    checkOutput("postrst_latency", 32'(lat), 32'd5);
    checkOutput("postrst_res", 32'(rsp_res), 32'd3);
    checkOutput("postrst_tag", 32'(rsp_tag), 32'd4);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
